// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, bus response codes, default NOP.
package ifu_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2,
        S_RESP = 2'd3
    } ifu_state_e;

    // Plain-vector aliases of the state encoding for code that keeps state in logic [1:0].
    localparam logic [1:0] ST_IDLE = S_IDLE;
    localparam logic [1:0] ST_AR   = S_AR;
    localparam logic [1:0] ST_R    = S_R;
    localparam logic [1:0] ST_RESP = S_RESP;

    localparam logic [1:0]  RESP_OKAY       = 2'b00;
    localparam logic [31:0] NOP_CMD_DEFAULT = 32'h0000_0013;  // addi x0,x0,0

endpackage

// File: rtl/ifu_fetch_if.sv
// Instruction-memory read bus: address channel plus data channel, valid/ready handshakes.
interface ifu_fetch_if;

    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output araddr, arvalid, rready,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  araddr, arvalid, rready,
        output arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/ifu_timeout.sv
// Stall timer for the bus-wait states: cleared on state entry, counts cycles spent waiting.
module ifu_timeout #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);
    localparam logic [W-1:0] CAP  = W'(TIMEOUT);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear wins, otherwise count up while enabled and saturate at TIMEOUT.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != CAP)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The current cycle is the TIMEOUT-th one spent waiting.
    assign expired = en && (cnt_q == LAST);

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one-entry last-fetch register in front of a valid/ready memory read bus.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for fetch_req; misaligned/hit answered without bus
// AR      | arvalid driven, waiting for arready (timed)
// R       | rready driven, waiting for rvalid (timed)
// RESP    | cmd_valid pulse for one cycle, then back to IDLE
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter logic [31:0] NOP_CMD = NOP_CMD_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_req,
    input  logic [31:0] pc,
    input  logic        flush,
    output logic [31:0] cmd,
    output logic        cmd_valid,
    output logic        fetch_err,
    output logic        busy,
    ifu_fetch_if.master bus
);

    logic [1:0]  state_q,      state_d;
    logic [31:0] cmd_q,        cmd_d;
    logic        cmd_valid_q,  cmd_valid_d;
    logic        fetch_err_q,  fetch_err_d;
    logic        busy_q,       busy_d;
    logic [31:0] araddr_q,     araddr_d;
    logic        arvalid_q,    arvalid_d;
    logic        rready_q,     rready_d;
    logic [31:0] last_pc_q,    last_pc_d;
    logic [31:0] last_cmd_q,   last_cmd_d;
    logic        last_v_q,     last_v_d;
    logic        flush_seen_q, flush_seen_d;

    logic tmo_clr;
    logic tmo_en;
    logic tmo_expired;

    // Timer restarts on every entry into a wait state and runs only while waiting.
    assign tmo_en  = (state_q == ST_AR) || (state_q == ST_R);
    assign tmo_clr = ((state_d == ST_AR) && (state_q != ST_AR)) ||
                     ((state_d == ST_R)  && (state_q != ST_R));

    ifu_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmo_clr),
        .en      (tmo_en),
        .expired (tmo_expired)
    );

    // Next-state and next-output logic for the whole fetch unit.
    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        fetch_err_d  = fetch_err_q;
        araddr_d     = araddr_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        last_pc_d    = last_pc_q;
        last_cmd_d   = last_cmd_q;
        last_v_d     = last_v_q;
        flush_seen_d = flush_seen_q | flush;

        case (state_q)
            ST_IDLE: begin
                if (fetch_req) begin
                    if (pc[1:0] != 2'b00) begin
                        state_d     = ST_RESP;
                        cmd_d       = NOP_CMD;
                        fetch_err_d = 1'b1;
                    end else if (last_v_q && (pc == last_pc_q) && !flush) begin
                        state_d     = ST_RESP;
                        cmd_d       = last_cmd_q;
                        fetch_err_d = 1'b0;
                    end else begin
                        // A flush in the request cycle also counts against this miss.
                        state_d      = ST_AR;
                        araddr_d     = pc;
                        arvalid_d    = 1'b1;
                        flush_seen_d = flush;
                    end
                end
            end
            ST_AR: begin
                if (arvalid_q && bus.arready) begin
                    state_d   = ST_R;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end else if (tmo_expired) begin
                    state_d     = ST_RESP;
                    arvalid_d   = 1'b0;
                    cmd_d       = NOP_CMD;
                    fetch_err_d = 1'b1;
                end
            end
            ST_R: begin
                if (rready_q && bus.rvalid) begin
                    state_d  = ST_RESP;
                    rready_d = 1'b0;
                    if (bus.rresp == RESP_OKAY) begin
                        cmd_d       = bus.rdata;
                        fetch_err_d = 1'b0;
                        if (!flush_seen_q && !flush) begin
                            last_pc_d  = araddr_q;
                            last_cmd_d = bus.rdata;
                            last_v_d   = 1'b1;
                        end
                    end else begin
                        cmd_d       = NOP_CMD;
                        fetch_err_d = 1'b1;
                    end
                end else if (tmo_expired) begin
                    state_d     = ST_RESP;
                    rready_d    = 1'b0;
                    cmd_d       = NOP_CMD;
                    fetch_err_d = 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (flush) begin
            last_v_d = 1'b0;
        end

        cmd_valid_d = (state_d == ST_RESP);
        busy_d      = (state_d == ST_AR) || (state_d == ST_R);
    end

    // All state and every output is registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cmd_q        <= NOP_CMD;
            cmd_valid_q  <= 1'b0;
            fetch_err_q  <= 1'b0;
            busy_q       <= 1'b0;
            araddr_q     <= '0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            last_pc_q    <= '0;
            last_cmd_q   <= '0;
            last_v_q     <= 1'b0;
            flush_seen_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            cmd_valid_q  <= cmd_valid_d;
            fetch_err_q  <= fetch_err_d;
            busy_q       <= busy_d;
            araddr_q     <= araddr_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            last_pc_q    <= last_pc_d;
            last_cmd_q   <= last_cmd_d;
            last_v_q     <= last_v_d;
            flush_seen_q <= flush_seen_d;
        end
    end

    assign cmd         = cmd_q;
    assign cmd_valid   = cmd_valid_q;
    assign fetch_err   = fetch_err_q;
    assign busy        = busy_q;
    assign bus.araddr  = araddr_q;
    assign bus.arvalid = arvalid_q;
    assign bus.rready  = rready_q;

endmodule
